// File: rtl/d5m_pwr_seq.sv
// d5m_pwr_seq
//   Power-up/power-down sequencer for the D5M camera front end. Brings the
//   pixel-clock divider up, releases the sensor reset, kicks the I2C config
//   engine and enables capture once configuration has completed. Shutdown
//   holds the sensor in reset for RST_HOLD cycles before the divider is gated.
//
// Ports
//   ck           in   system clock (rising edge)
//   reset        in   asynchronous reset, active low
//   start        in   level, sampled only in IDLE
//   stop         in   level, shutdown request from any active state
//   cfg_done     in   config engine success pulse
//   cfg_err      in   config engine failure pulse
//   div_en       out  clock divider enable
//   sensor_rst_n out  sensor reset pin, active low
//   cfg_start    out  one-cycle config engine start pulse
//   capture_en   out  pixel capture path enable
//   ready        out  high in RUN
//   fault        out  high in FAULT
//   state        out  debug state encoding (IDLE=0 .. SHUTDOWN=6)

module d5m_pwr_seq #(
    parameter int unsigned CLK_EN_DELAY = 1000,
    parameter int unsigned CFG_WAIT     = 2000,
    parameter int unsigned CFG_TIMEOUT  = 500000,
    parameter int unsigned RST_HOLD     = 100
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       cfg_done,
    input  logic       cfg_err,
    output logic       div_en,
    output logic       sensor_rst_n,
    output logic       cfg_start,
    output logic       capture_en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLK_ON   = 3'd1,
        S_RST_REL  = 3'd2,
        S_CFG      = 3'd3,
        S_RUN      = 3'd4,
        S_FAULT    = 3'd5,
        S_SHUTDOWN = 3'd6
    } state_t;

    // The counter is loaded with N-1 on entry and the state exits on the
    // edge that sees zero, so each timed state lasts exactly N cycles.
    localparam logic [19:0] LD_CLK_ON  = 20'(CLK_EN_DELAY - 1);
    localparam logic [19:0] LD_RST_REL = 20'(CFG_WAIT - 1);
    localparam logic [19:0] LD_CFG     = 20'(CFG_TIMEOUT - 1);
    localparam logic [19:0] LD_HOLD    = 20'(RST_HOLD - 1);

    state_t      cur;
    state_t      nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic        cnt_zero;

    logic div_en_nxt;
    logic sensor_rst_n_nxt;
    logic cfg_start_nxt;
    logic capture_en_nxt;
    logic ready_nxt;
    logic fault_nxt;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            cur          <= S_IDLE;
            cnt          <= '0;
            div_en       <= 1'b0;
            sensor_rst_n <= 1'b0;
            cfg_start    <= 1'b0;
            capture_en   <= 1'b0;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            cur          <= nxt;
            cnt          <= cnt_nxt;
            div_en       <= div_en_nxt;
            sensor_rst_n <= sensor_rst_n_nxt;
            cfg_start    <= cfg_start_nxt;
            capture_en   <= capture_en_nxt;
            ready        <= ready_nxt;
            fault        <= fault_nxt;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE: begin
                if (start && !stop) nxt = S_CLK_ON;
            end
            S_CLK_ON: begin
                if (stop)          nxt = S_SHUTDOWN;
                else if (cnt_zero) nxt = S_RST_REL;
            end
            S_RST_REL: begin
                if (stop)          nxt = S_SHUTDOWN;
                else if (cnt_zero) nxt = S_CFG;
            end
            S_CFG: begin
                // A response on the final timeout cycle still counts.
                if (stop)          nxt = S_SHUTDOWN;
                else if (cfg_err)  nxt = S_FAULT;
                else if (cfg_done) nxt = S_RUN;
                else if (cnt_zero) nxt = S_FAULT;
            end
            S_RUN: begin
                if (stop) nxt = S_SHUTDOWN;
            end
            S_FAULT: begin
                if (stop) nxt = S_SHUTDOWN;
            end
            S_SHUTDOWN: begin
                if (cnt_zero) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (nxt != cur) begin
            unique case (nxt)
                S_CLK_ON:   cnt_nxt = LD_CLK_ON;
                S_RST_REL:  cnt_nxt = LD_RST_REL;
                S_CFG:      cnt_nxt = LD_CFG;
                S_SHUTDOWN: cnt_nxt = LD_HOLD;
                default:    cnt_nxt = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_nxt = cnt - 20'd1;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        div_en_nxt       = (nxt != S_IDLE);
        sensor_rst_n_nxt = (nxt == S_RST_REL) || (nxt == S_CFG) || (nxt == S_RUN);
        cfg_start_nxt    = (nxt == S_CFG) && (cur != S_CFG);
        capture_en_nxt   = (nxt == S_RUN);
        ready_nxt        = (nxt == S_RUN);
        fault_nxt        = (nxt == S_FAULT);
    end

    assign state = cur;

endmodule

// File: doc/d5m_pwr_seq.md
# d5m_pwr_seq

Power-up/power-down sequencer for the D5M camera front end. It gates the pixel-clock divider enable, drives the sensor reset pin, and triggers the I2C register-configuration engine with a done/error handshake. Capture is enabled only after the full sequence completes. It sits between the top-level control logic and the clock divider, the sensor pins and the I2C config block.

## Interface
- CLK_EN_DELAY, 1000: cycles from `div_en` rising to `sensor_rst_n` rising (range 1..2^20-1).
- CFG_WAIT, 2000: cycles from `sensor_rst_n` rising to the `cfg_start` pulse (range 1..2^20-1).
- CFG_TIMEOUT, 500000: maximum cycles allowed for the config handshake (range 1..2^20-1).
- RST_HOLD, 100: cycles `sensor_rst_n` is held low before `div_en` drops on shutdown (range 1..2^20-1).
- ck  in  1  system clock; all logic is rising-edge.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  level; sampled only in IDLE.
- stop  in  1  level; requests shutdown from any non-IDLE, non-SHUTDOWN state.
- cfg_done  in  1  one-cycle pulse from the config engine: configuration succeeded.
- cfg_err  in  1  one-cycle pulse from the config engine: configuration failed (I2C NACK).
- div_en  out  1  enable to the clock divider.
- sensor_rst_n  out  1  sensor reset pin, active-low.
- cfg_start  out  1  one-cycle pulse that starts the config engine.
- capture_en  out  1  enables the pixel capture path.
- ready  out  1  high in RUN.
- fault  out  1  high in FAULT.
- state  out  3  encoded state, for debug: IDLE=0, CLK_ON=1, RST_REL=2, CFG=3, RUN=4, FAULT=5, SHUTDOWN=6.

## Operation
- All outputs are registered. Reset values: `div_en`=0, `sensor_rst_n`=0, `cfg_start`=0, `capture_en`=0, `ready`=0, `fault`=0, `state`=0.
- A single 20-bit down-counter is reloaded on each state entry.
- **IDLE:** all outputs at reset values.
  - `start`=1 and `stop`=0 → CLK_ON.
  - `stop` has priority over `start`.
- **CLK_ON:** `div_en`=1, `sensor_rst_n`=0. After CLK_EN_DELAY cycles → RST_REL.
- **RST_REL:** `sensor_rst_n`=1. After CFG_WAIT cycles → CFG.
- **CFG:** `cfg_start`=1 on the first cycle only, then waits.
  - `cfg_err` → FAULT.
  - `cfg_done` → RUN.
  - If both arrive in the same cycle, `cfg_err` wins.
  - No response within CFG_TIMEOUT cycles after the `cfg_start` pulse → FAULT.
- **RUN:** `capture_en`=1, `ready`=1. Remains here until `stop`.
- **FAULT:** `fault`=1, `sensor_rst_n`=0, `div_en`=1, `capture_en`=0. Only `stop` leaves this state; `start` is ignored.
- **SHUTDOWN:**
  - `capture_en`, `ready`, `fault` and `sensor_rst_n` all go low on the entry cycle.
  - `div_en` stays 1 for RST_HOLD cycles, then → IDLE, where `div_en` becomes 0.
- `stop` in CLK_ON, RST_REL, CFG, RUN or FAULT → SHUTDOWN on the next edge, taking priority over every other transition in the same cycle.
- `stop` is ignored in IDLE and in SHUTDOWN.
- `start` is ignored outside IDLE.
- A `cfg_done` or `cfg_err` pulse received outside CFG is ignored.
- Asserting reset mid-sequence forces all outputs to their reset values immediately (asynchronously). This drops `div_en` without an RST_HOLD period.

## Timing
- Edge 0 samples `start`=1 in IDLE. From edge 1: `div_en`=1, `state`=1.
- `sensor_rst_n` rises at edge 1+CLK_EN_DELAY.
- `cfg_start` is high for the single cycle following edge 1+CLK_EN_DELAY+CFG_WAIT.
- `cfg_done` sampled at edge N → `capture_en`=`ready`=1 from edge N+1.
- Timeout: with the `cfg_start` pulse in cycle C and no response, FAULT is entered at edge C+CFG_TIMEOUT.
  - A `cfg_done` sampled at edge C+CFG_TIMEOUT is still accepted, so the bound is inclusive.
- `stop` sampled at edge S → `capture_en`=0 and `sensor_rst_n`=0 from edge S+1; `div_en`=0 from edge S+1+RST_HOLD.
- Shutdown latency back to IDLE is RST_HOLD+1 cycles.

## Test plan
Parameters for all scenarios: CLK_EN_DELAY=4, CFG_WAIT=6, CFG_TIMEOUT=10, RST_HOLD=3.
- **Nominal bring-up:** `start` pulse at edge 0; `cfg_done` 2 cycles after `cfg_start`.
  - Expect `div_en` from edge 1, `sensor_rst_n` from edge 5, `cfg_start` exactly 1 cycle after edge 11, and `ready`=`capture_en`=1 at edge 14.
- **Config error:** `cfg_err` 3 cycles after `cfg_start` → `fault`=1, `sensor_rst_n`=0, `div_en`=1.
  - Then `start` → no change; then `stop` → `div_en` drops 3 cycles after SHUTDOWN entry, `state`=0.
- **Timeout:** no response → `fault`=1 exactly 10 cycles after `cfg_start`.
  - Repeat with `cfg_done` arriving at cycle 10 → RUN instead of FAULT.
- **Simultaneous events:**
  - `cfg_done` and `cfg_err` in the same cycle → FAULT.
  - `stop` and `cfg_done` in the same cycle → SHUTDOWN; `capture_en` never asserts.
- **Stop from RUN:** `stop` at edge S → `capture_en`=0 at S+1, `div_en`=0 at S+4, `state`=0 at S+4.
  - A `stop` held high in IDLE does not block a later `start` after `stop` is released.
- **Async reset mid-sequence:** assert reset during RST_REL → all outputs 0 immediately, with no wait for a clock edge.
  - After release, a full bring-up reproduces the nominal timing.
